// File: rtl/anc_sequencer.sv
// rtl/anc_sequencer.sv - ANC adaptation sequencer: pairs mic samples, schedules LMS step size, detects divergence
module anc_sequencer #(
    parameter int                         NB_DATA  = 21,
    parameter int                         NBF_DATA = 20,
    parameter logic signed [NB_DATA-1:0]  MU_FAST  = 21'sh08000,
    parameter logic signed [NB_DATA-1:0]  MU_SLOW  = 21'sh00800,
    parameter int                         N_WARMUP = 4,
    parameter int                         N_FAST   = 1024,
    parameter logic signed [NB_DATA-1:0]  ERR_THR  = 21'sh60000,
    parameter int                         N_DIV    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_freeze,
    input  logic [NB_DATA-1:0]        i_mic1,
    input  logic                      i_mic1_valid,
    output logic                      o_mic1_ready,
    input  logic [NB_DATA-1:0]        i_mic2,
    input  logic                      i_mic2_valid,
    output logic                      o_mic2_ready,
    input  logic signed [NB_DATA-1:0] i_error,
    output logic [NB_DATA-1:0]        o_mic1,
    output logic [NB_DATA-1:0]        o_mic2,
    output logic                      o_sample_en,
    output logic signed [NB_DATA-1:0] o_mu,
    output logic                      o_filt_rst,
    output logic [2:0]                o_state
);
    localparam int MAX_A = (N_FAST > N_WARMUP) ? N_FAST : N_WARMUP;
    localparam int MAX_N = (MAX_A > N_DIV) ? MAX_A : N_DIV;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(N_WARMUP - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(N_FAST - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(N_DIV - 1);
    localparam logic signed [NB_DATA:0] THR_EXT = {ERR_THR[NB_DATA-1], ERR_THR};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_FAST   = 3'd2,
        S_SLOW   = 3'd3,
        S_FREEZE = 3'd4
    } state_t;

    state_t                     state, state_nxt, saved_q, saved_nxt;
    logic [CNT_W-1:0]           smp_cnt, smp_cnt_nxt, div_cnt, div_cnt_nxt;
    logic signed [NB_DATA-1:0]  mu_nxt;
    logic                       filt_rst_nxt, diverge, fire, err_en;
    logic                       mic1_full, mic2_full;
    logic [NB_DATA-1:0]         mic1_q, mic2_q;
    logic signed [NB_DATA:0]    err_ext, err_mag;
    logic                       over_thr;

    assign o_state      = state;
    assign o_mic1_ready = (state != S_IDLE) && !mic1_full;
    assign o_mic2_ready = (state != S_IDLE) && !mic2_full;
    assign fire         = i_enable && (state != S_IDLE) && mic1_full && mic2_full;

    // One extra bit so the most negative error still has a representable magnitude
    assign err_ext  = {i_error[NB_DATA-1], i_error};
    assign err_mag  = err_ext[NB_DATA] ? -err_ext : err_ext;
    assign over_thr = (err_mag >= THR_EXT);

    always_comb begin
        state_nxt   = state;
        saved_nxt   = saved_q;
        smp_cnt_nxt = smp_cnt;
        div_cnt_nxt = div_cnt;
        diverge     = 1'b0;
        if (err_en && (state == S_FAST || state == S_SLOW)) begin
            if (!over_thr)
                div_cnt_nxt = '0;
            else if (div_cnt == DIV_LAST)
                diverge = 1'b1;
            else
                div_cnt_nxt = div_cnt + CNT_W'(1);
        end
        if (!i_enable) begin
            state_nxt   = S_IDLE;
            smp_cnt_nxt = '0;
            div_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt   = S_WARMUP;
                    smp_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                end
                S_WARMUP: begin
                    if (fire) begin
                        if (smp_cnt == WARM_LAST) begin
                            state_nxt   = S_FAST;
                            smp_cnt_nxt = '0;
                        end else begin
                            smp_cnt_nxt = smp_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FAST, S_SLOW: begin
                    if (diverge) begin
                        state_nxt   = S_WARMUP;
                        smp_cnt_nxt = '0;
                        div_cnt_nxt = '0;
                    end else if (i_freeze) begin
                        saved_nxt = state;
                        state_nxt = S_FREEZE;
                    end else if (fire && state == S_FAST) begin
                        if (smp_cnt == FAST_LAST) begin
                            state_nxt   = S_SLOW;
                            smp_cnt_nxt = '0;
                        end else begin
                            smp_cnt_nxt = smp_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FREEZE: begin
                    if (!i_freeze)
                        state_nxt = saved_q;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        case (state_nxt)
            S_FAST:  mu_nxt = MU_FAST;
            S_SLOW:  mu_nxt = MU_SLOW;
            default: mu_nxt = '0;
        endcase
        filt_rst_nxt = (state_nxt == S_WARMUP) && (state != S_WARMUP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            saved_q    <= S_FAST;
            smp_cnt    <= '0;
            div_cnt    <= '0;
            o_mu       <= '0;
            o_filt_rst <= 1'b0;
        end else begin
            state      <= state_nxt;
            saved_q    <= saved_nxt;
            smp_cnt    <= smp_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            o_mu       <= mu_nxt;
            o_filt_rst <= filt_rst_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mic1_full   <= 1'b0;
            mic2_full   <= 1'b0;
            mic1_q      <= '0;
            mic2_q      <= '0;
            o_mic1      <= '0;
            o_mic2      <= '0;
            o_sample_en <= 1'b0;
            err_en      <= 1'b0;
        end else begin
            o_sample_en <= fire;
            err_en      <= o_sample_en;
            if (!i_enable || state == S_IDLE) begin
                mic1_full <= 1'b0;
                mic2_full <= 1'b0;
            end else if (fire) begin
                mic1_full <= 1'b0;
                mic2_full <= 1'b0;
                o_mic1    <= mic1_q;
                o_mic2    <= mic2_q;
            end else begin
                if (i_mic1_valid && o_mic1_ready) begin
                    mic1_q    <= i_mic1;
                    mic1_full <= 1'b1;
                end
                if (i_mic2_valid && o_mic2_ready) begin
                    mic2_q    <= i_mic2;
                    mic2_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_anc_sequencer.sv
// tb/tb_anc_sequencer.sv - scoreboard bench for anc_sequencer
module tb_anc_sequencer;
    localparam int NB = 21;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_enable = 1'b0;
    logic                 i_freeze = 1'b0;
    logic [NB-1:0]        i_mic1 = '0;
    logic                 i_mic1_valid = 1'b0;
    logic                 o_mic1_ready;
    logic [NB-1:0]        i_mic2 = '0;
    logic                 i_mic2_valid = 1'b0;
    logic                 o_mic2_ready;
    logic signed [NB-1:0] i_error = '0;
    logic [NB-1:0]        o_mic1, o_mic2;
    logic                 o_sample_en;
    logic signed [NB-1:0] o_mu;
    logic                 o_filt_rst;
    logic [2:0]           o_state;

    anc_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_freeze(i_freeze),
        .i_mic1(i_mic1), .i_mic1_valid(i_mic1_valid), .o_mic1_ready(o_mic1_ready),
        .i_mic2(i_mic2), .i_mic2_valid(i_mic2_valid), .o_mic2_ready(o_mic2_ready),
        .i_error(i_error), .o_mic1(o_mic1), .o_mic2(o_mic2), .o_sample_en(o_sample_en),
        .o_mu(o_mu), .o_filt_rst(o_filt_rst), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int fire_cnt = 0;
    int left1 = 0, left2 = 0;
    int seq1 = 0, seq2 = 0;
    logic [NB-1:0] q1[$], q2[$];
    logic [NB-1:0] err_q[$];
    logic [NB-1:0] err_level = 21'h1F0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (o_state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(o_state), 32'(s));
    endtask

    task automatic wait_both_full(input string tag);
        int k = 0;
        while ((o_mic1_ready || o_mic2_ready) && k < 20) begin
            tick(1);
            k++;
        end
        check(tag, 32'(!o_mic1_ready && !o_mic2_ready), 32'd1);
    endtask

    // Sources: a word is expected at the filter once it has been accepted
    initial begin
        logic take1, take2;
        forever begin
            @(negedge i_clk);
            take1 = i_mic1_valid && o_mic1_ready;
            take2 = i_mic2_valid && o_mic2_ready;
            @(posedge i_clk);
            #1;
            if (take1) begin
                q1.push_back(i_mic1);
                seq1++;
                if (left1 > 0) left1--;
            end
            if (take2) begin
                q2.push_back(i_mic2);
                seq2++;
                if (left2 > 0) left2--;
            end
            i_mic1       = NB'(seq1 * 3 + 1);
            i_mic1_valid = (left1 != 0);
            i_mic2       = NB'(21'h100000 ^ seq2);
            i_mic2_valid = (left2 != 0);
        end
    end

    // Filter side: compare each fired pair, then present the error for that sample
    initial begin
        logic [NB-1:0] e1, e2;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_sample_en) begin
                fire_cnt++;
                if (q1.size() == 0 || q2.size() == 0) begin
                    check("sb_underflow", 32'(q1.size() * q2.size()), 32'd1);
                end else begin
                    e1 = q1.pop_front();
                    e2 = q2.pop_front();
                    check("sb_mic1", 32'(o_mic1), 32'(e1));
                    check("sb_mic2", 32'(o_mic2), 32'(e2));
                end
                i_error = (err_q.size() != 0) ? err_q.pop_front() : err_level;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k;
        tick(3);
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_mu", 32'(o_mu), 32'd0);
        check("rst_sample_en", 32'(o_sample_en), 32'd0);
        check("rst_filt_rst", 32'(o_filt_rst), 32'd0);
        check("rst_ready", 32'({o_mic1_ready, o_mic2_ready}), 32'd0);
        check("rst_mic", 32'({o_mic1, o_mic2}), 32'd0);
        i_rst_n = 1'b1;
        left1 = -1;
        left2 = -1;
        tick(4);
        check("idle_hold", 32'(o_state), 32'd0);
        check("idle_ready", 32'({o_mic1_ready, o_mic2_ready}), 32'd0);

        base = fire_cnt;
        i_enable = 1'b1;
        tick(1);
        check("warm_state", 32'(o_state), 32'd1);
        check("warm_filt_rst", 32'(o_filt_rst), 32'd1);
        check("warm_mu", 32'(o_mu), 32'd0);
        tick(1);
        check("warm_filt_rst_1cyc", 32'(o_filt_rst), 32'd0);
        wait_state(3'd2, 60, "fast_entry");
        check("warm_fires", 32'(fire_cnt - base), 32'd4);
        check("fast_mu", 32'(o_mu), 32'h08000);

        base = fire_cnt;
        wait_state(3'd3, 2300, "slow_entry");
        check("fast_fires", 32'(fire_cnt - base), 32'd1024);
        check("slow_mu", 32'(o_mu), 32'h00800);

        i_freeze = 1'b1;
        tick(1);
        check("frz_state", 32'(o_state), 32'd4);
        check("frz_mu", 32'(o_mu), 32'd0);
        base = fire_cnt;
        tick(20);
        check("frz_fires", 32'(fire_cnt - base >= 9), 32'd1);
        err_level = 21'h100000;
        tick(40);
        check("frz_no_div", 32'(o_state), 32'd4);
        err_level = 21'h1F0000;
        tick(8);
        i_freeze = 1'b0;
        tick(1);
        check("unfrz_state", 32'(o_state), 32'd3);
        check("unfrz_mu", 32'(o_mu), 32'h00800);

        for (int i = 0; i < 15; i++) err_q.push_back(21'h100000);
        err_q.push_back(21'h05FFFF);
        base = fire_cnt;
        k = 0;
        while (fire_cnt - base < 20 && k < 80) begin
            tick(1);
            k++;
        end
        check("near_div_fires", 32'(fire_cnt - base >= 20), 32'd1);
        check("near_div_state", 32'(o_state), 32'd3);

        for (int i = 0; i < 14; i++) err_q.push_back(21'h100000);
        err_q.push_back(21'h060000);
        err_q.push_back(21'h1A0000);
        wait_state(3'd1, 100, "div_state");
        check("div_filt_rst", 32'(o_filt_rst), 32'd1);
        check("div_mu", 32'(o_mu), 32'd0);
        wait_state(3'd2, 60, "div_refast");

        left1 = 0;
        left2 = 0;
        tick(8);
        base = fire_cnt;
        left1 = 1;
        tick(10);
        check("skew_no_fire", 32'(fire_cnt - base), 32'd0);
        check("skew_mic1_ready", 32'(o_mic1_ready), 32'd0);
        check("skew_mic2_ready", 32'(o_mic2_ready), 32'd1);
        left2 = 1;
        tick(10);
        check("skew_one_fire", 32'(fire_cnt - base), 32'd1);
        check("skew_ready_after", 32'({o_mic1_ready, o_mic2_ready}), 32'd3);

        left1 = -1;
        left2 = -1;
        tick(3);
        wait_both_full("dis_setup");
        i_enable = 1'b0;
        base = fire_cnt;
        tick(1);
        check("dis_state", 32'(o_state), 32'd0);
        check("dis_sample_en", 32'(o_sample_en), 32'd0);
        check("dis_ready", 32'({o_mic1_ready, o_mic2_ready}), 32'd0);
        q1.delete();
        q2.delete();
        tick(4);
        check("dis_no_fire", 32'(fire_cnt - base), 32'd0);

        i_enable = 1'b1;
        wait_state(3'd2, 60, "rst_fast");
        wait_both_full("rst_setup");
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        #1;
        check("arst_state", 32'(o_state), 32'd0);
        check("arst_mu", 32'(o_mu), 32'd0);
        check("arst_ctrl", 32'({o_sample_en, o_filt_rst}), 32'd0);
        check("arst_ready", 32'({o_mic1_ready, o_mic2_ready}), 32'd0);
        check("arst_mic", 32'({o_mic1, o_mic2}), 32'd0);
        q1.delete();
        q2.delete();
        tick(2);
        i_rst_n = 1'b1;
        tick(3);
        check("post_rst_idle", 32'(o_state), 32'd0);
        i_enable = 1'b1;
        tick(1);
        check("post_rst_warm", 32'({o_state, o_filt_rst}), 32'({3'd1, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/anc_sequencer.md
ANC_SEQUENCER -- requirements
Module: anc_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NB_DATA, 21, sample/coefficient word width
- NBF_DATA, 20, fractional bits
- MU_FAST, 21'sh08000 (0.03125), step size while converging
- MU_SLOW, 21'sh00800 (~0.00195), step size while tracking
- N_WARMUP, 4, samples to fill the tap line
- N_FAST, 1024, samples spent in fast adaptation
- ERR_THR, 21'sh60000 (0.375), divergence magnitude threshold
- N_DIV, 16, consecutive over-threshold errors that declare divergence
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, single clock; all state on rising edge
- i_rst_n, in, 1, reset; one clock; reset is asynchronous and active-low
- i_enable, in, 1, run request
- i_freeze, in, 1, hold coefficients (mu forced 0)
- i_mic1 / i_mic1_valid / o_mic1_ready, in/in/out, NB_DATA/1/1, reference-mic stream
- i_mic2 / i_mic2_valid / o_mic2_ready, in/in/out, NB_DATA/1/1, primary-mic stream
- i_error, in, NB_DATA signed, filter error output (NB_DATA, NBF_DATA)
- o_mic1, o_mic2, out, NB_DATA, paired sample to filter
- o_sample_en, out, 1, one-cycle filter sample enable
- o_mu, out, NB_DATA signed, step size to filter LMS
- o_filt_rst, out, 1, active-high synchronous filter/coefficient clear pulse
- o_state, out, 3, current state encoding

Function
REQ-003 Each stream SHALL have a one-entry holding register; ready = !full; a word is captured when valid && ready.
REQ-004 A fire SHALL occur in a cycle where both holding registers are full and state is WARMUP, FAST, SLOW or FREEZE.
REQ-005 On fire: o_sample_en=1 for exactly that cycle, o_mic1/o_mic2 present held words, both registers empty at next edge; readies rise the following cycle (max one fire per 2 cycles).
REQ-006 o_mic1/o_mic2 SHALL be registered and hold last fired value between fires.
REQ-007 i_error SHALL be sampled in the cycle after each fire (one per fire); magnitude computed in NB_DATA+1 bits so -2^20 maps to +2^20.
REQ-008 States: IDLE=0, WARMUP=1, FAST=2, SLOW=3, FREEZE=4.
REQ-009 o_mu: 0 in IDLE, WARMUP, FREEZE; MU_FAST in FAST; MU_SLOW in SLOW; registered, changes on the state-transition edge.
REQ-010 IDLE -> WARMUP when i_enable=1; o_filt_rst pulses one cycle on every WARMUP entry; sample counter cleared.
REQ-011 WARMUP -> FAST after N_WARMUP fires; FAST -> SLOW after N_FAST fires counted in FAST; counter cleared on each transition.
REQ-012 FAST/SLOW -> FREEZE while i_freeze=1; FREEZE returns to the saved state (FAST or SLOW) when i_freeze=0; sample counter held, fires continue in FREEZE.
REQ-013 Divergence: in FAST or SLOW, error magnitude >= ERR_THR on N_DIV consecutive sampled errors -> WARMUP (with o_filt_rst); any sample below threshold clears the run counter; run counter frozen in FREEZE and cleared on WARMUP entry.
REQ-014 i_enable=0 in any state -> IDLE next edge; holding registers flushed; o_sample_en suppressed that cycle; readies low in IDLE.
REQ-015 Priority per cycle: disable > divergence > freeze > count-based transition.
REQ-016 Counter widths SHALL be $clog2(max(N_FAST,N_WARMUP,N_DIV)+1); no wrap permitted.

Reset
REQ-017 While i_rst_n=0: state IDLE, o_mu=0, o_sample_en=0, o_filt_rst=0, o_mic1=o_mic2=0, readies 0, all counters and holding registers cleared; asserting mid-operation aborts immediately with no pulse.
REQ-018 After deassertion the block SHALL remain in IDLE until i_enable=1.

Verification
REQ-019 Enable, both streams valid continuously -> o_filt_rst 1 cycle, o_state 1, 4 fires with mu=0, then o_state 2 with o_mu=0x08000.
REQ-020 After 1024 FAST fires with small error -> o_state 3, o_mu=0x00800; fire count and paired samples match input order.
REQ-021 mic1 valid 10 cycles before mic2 -> no fire until mic2 captured; o_mic1_ready low meanwhile; exactly one fire.
REQ-022 In SLOW, i_error=21'sh100000 (-1.0) for 16 fires -> WARMUP, o_filt_rst pulse, o_mu=0; 15 then one below threshold -> stays SLOW.
REQ-023 i_freeze during SLOW -> o_state 4, o_mu=0, fires continue; release -> SLOW, o_mu=0x00800; freeze plus divergence-level error -> no recovery.
REQ-024 i_rst_n low mid-FAST with both registers full -> all outputs reset asynchronously; i_enable=0 mid-run -> IDLE, no fire that cycle.
